// File: rtl/grid_move_sequencer_pkg.sv
// grid_move_sequencer_pkg: shared grid geometry, cell values and controller states
package grid_move_sequencer_pkg;
    localparam int GRID_DIM = 4;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
    localparam int CELL_W = 2;
    localparam logic [CELL_W-1:0] CELL_CLEAR = 2'b00;
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SCRAMBLE, S_PLAY, S_FIRE, S_SETTLE, S_CHECK, S_WON
    } state_e;
endpackage

// File: rtl/grid_move_sequencer_if.sv
// grid_move_sequencer_if: player/win inputs and cell strike/load bus of the game controller
interface grid_move_sequencer_if
    import grid_move_sequencer_pkg::*;
#(
    parameter int MOVE_CNT_W = 8
);
    logic fire_req, new_game, mix_mode, sel_error, n_row, win;
    logic [GRID_DIM-1:0] sel_code, row_en, col_en;
    logic add_n, fire_pulse, load_en, busy, game_won;
    logic [$clog2(NUM_CELLS)-1:0] load_idx;
    logic [CELL_W-1:0] load_val;
    logic [MOVE_CNT_W-1:0] move_count;
    modport master (
        input fire_req, new_game, mix_mode, sel_code, sel_error, n_row, win,
        output row_en, col_en, add_n, fire_pulse, load_en, load_idx, load_val, move_count, busy, game_won
    );
    modport slave (
        output fire_req, new_game, mix_mode, sel_code, sel_error, n_row, win,
        input row_en, col_en, add_n, fire_pulse, load_en, load_idx, load_val, move_count, busy, game_won
    );
endinterface

// File: rtl/grid_move_sequencer_lfsr.sv
// grid_move_sequencer_lfsr: 16-bit Galois LFSR (taps 16/14/13/11) exposing its low bits
module grid_move_sequencer_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adv,
    output logic [2:0] pick
);
    logic [15:0] q;
    assign pick = q[2:0];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) q <= SEED;
        else if (adv) q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/grid_move_sequencer.sv
// grid_move_sequencer: clears/scrambles the grid and turns fire presses into validated strikes
module grid_move_sequencer
    import grid_move_sequencer_pkg::*;
#(
    parameter int SCRAMBLE_MOVES = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int MOVE_CNT_W = 8
) (
    input logic clk,
    input logic reset_n,
    grid_move_sequencer_if.master bus
);
    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d, sc_q, sc_d;
    logic fire_q, ng_q, fire_edge, ng_edge, strike_d, fire_d;
    logic [2:0] pick;
    logic [GRID_DIM-1:0] scr_oh;
    assign fire_edge = bus.fire_req && !fire_q;
    assign ng_edge = bus.new_game && !ng_q;
    assign strike_d = state_d == S_SCRAMBLE && cnt_d == 8'd0;
    assign fire_d = state_d == S_FIRE;
    assign scr_oh = 4'b0001 << pick[1:0];
    assign bus.load_val = CELL_CLEAR;

    grid_move_sequencer_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk(clk), .reset_n(reset_n), .adv(strike_d), .pick(pick)
    );

    // cnt_q is the clear index in S_CLEAR and the strike/settle phase elsewhere
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sc_d = sc_q;
        if (ng_edge) begin
            state_d = S_CLEAR;
            cnt_d = '0;
        end else
            case (state_q)
                S_CLEAR: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(NUM_CELLS - 1)) begin
                        cnt_d = '0;
                        sc_d = '0;
                        state_d = (bus.mix_mode && SCRAMBLE_MOVES > 0) ? S_SCRAMBLE : S_PLAY;
                    end
                end
                S_SCRAMBLE: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(SETTLE_CYCLES)) begin
                        cnt_d = '0;
                        sc_d = sc_q + 8'd1;
                        state_d = sc_q == 8'(SCRAMBLE_MOVES - 1) ? S_PLAY : S_SCRAMBLE;
                    end
                end
                S_PLAY: state_d = (fire_edge && !bus.sel_error && $onehot(bus.sel_code)) ? S_FIRE : S_PLAY;
                S_FIRE: begin
                    state_d = S_SETTLE;
                    cnt_d = 8'd1;
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + 8'd1;
                    state_d = cnt_q == 8'(SETTLE_CYCLES) ? S_CHECK : S_SETTLE;
                end
                S_CHECK: state_d = bus.win ? S_WON : S_PLAY;
                default: ;
            endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            sc_q <= '0;
            fire_q <= 1'b0;
            ng_q <= 1'b0;
            bus.row_en <= '0;
            bus.col_en <= '0;
            bus.add_n <= 1'b0;
            bus.fire_pulse <= 1'b0;
            bus.load_en <= 1'b0;
            bus.load_idx <= '0;
            bus.move_count <= '0;
            bus.busy <= 1'b0;
            bus.game_won <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sc_q <= sc_d;
            fire_q <= bus.fire_req;
            ng_q <= bus.new_game;
            bus.row_en <= strike_d ? (pick[2] ? '0 : scr_oh) : (fire_d && !bus.n_row) ? bus.sel_code : '0;
            bus.col_en <= strike_d ? (pick[2] ? scr_oh : '0) : (fire_d && bus.n_row) ? bus.sel_code : '0;
            bus.add_n <= strike_d;
            bus.fire_pulse <= strike_d || fire_d;
            bus.load_en <= state_d == S_CLEAR;
            bus.load_idx <= state_d == S_CLEAR ? cnt_d[3:0] : '0;
            bus.move_count <= state_q == S_CLEAR ? '0 :
                (state_q == S_FIRE && bus.move_count != {MOVE_CNT_W{1'b1}}) ? bus.move_count + 1'b1 : bus.move_count;
            bus.busy <= !(state_d inside {S_PLAY, S_WON});
            bus.game_won <= state_d == S_WON;
        end
endmodule

// File: tb/tb_grid_move_sequencer.sv
// tb_grid_move_sequencer: randomized scoreboard bench with a behavioural game model
module tb_grid_move_sequencer;
    typedef struct packed {
        logic       add_n;
        logic [3:0] row;
        logic [3:0] col;
    } strike_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    strike_t sq[$];
    int lq[$];
    strike_t mon_s;
    int mon_i;
    logic [15:0] mlfsr = 16'hACE1;
    int mc = 0;

    grid_move_sequencer_if #(.MOVE_CNT_W(8)) bus ();
    grid_move_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // monitor: strikes and loads are checked against the queues filled by the stimulus
    always @(negedge clk) if (reset_n) begin
        checks++;
        if (bus.fire_pulse) begin
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL strike_unexpected add_n=%b row=%b col=%b", bus.add_n, bus.row_en, bus.col_en);
            end else begin
                mon_s = sq.pop_front();
                if ({bus.add_n, bus.row_en, bus.col_en} !== mon_s) begin
                    errors++;
                    $display("FAIL strike add_n/row/col actual=%b/%b/%b expected=%b/%b/%b",
                             bus.add_n, bus.row_en, bus.col_en, mon_s.add_n, mon_s.row, mon_s.col);
                end
            end
        end else if ((bus.row_en | bus.col_en) != 4'b0) begin
            errors++;
            $display("FAIL idle_enables row=%b col=%b expected 0", bus.row_en, bus.col_en);
        end
        if (bus.load_en) begin
            checks++;
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected idx=%0d", bus.load_idx);
            end else begin
                mon_i = lq.pop_front();
                if (bus.load_idx != 4'(mon_i) || bus.load_val != 2'b00) begin
                    errors++;
                    $display("FAIL load idx/val actual=%0d/%0d expected=%0d/0", bus.load_idx, bus.load_val, mon_i);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", int'(n < 300), 1);
    endtask

    task automatic ng_pulse(input int n, input logic mix);
        logic [3:0] oh;
        @(negedge clk);
        bus.mix_mode = mix;
        bus.new_game = 1'b1;
        for (int i = 0; i < n; i++) lq.push_back(i);
        if (mix && n == 16) begin
            for (int i = 0; i < 8; i++) begin
                oh = 4'b0001 << mlfsr[1:0];
                sq.push_back({1'b1, mlfsr[2] ? 4'b0 : oh, mlfsr[2] ? oh : 4'b0});
                mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
            end
        end
        if (n == 16) mc = 0;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic do_fire(input logic [3:0] sel, input logic err, input logic nrow, input logic live);
        logic acc;
        acc = live && !err && $countones(sel) == 1;
        @(negedge clk);
        bus.sel_code = sel;
        bus.sel_error = err;
        bus.n_row = nrow;
        bus.fire_req = 1'b1;
        if (acc) begin
            sq.push_back({1'b0, nrow ? 4'b0 : sel, nrow ? sel : 4'b0});
            if (mc < 255) mc++;
        end
        @(negedge clk);
        chk("fire_pulse_latency", int'(bus.fire_pulse), int'(acc));
        bus.fire_req = 1'b0;
        bus.sel_code = 4'($urandom);
        bus.n_row = ~nrow;
    endtask

    initial begin
        logic [3:0] sel;
        bus.fire_req = 0; bus.new_game = 0; bus.mix_mode = 0; bus.sel_code = 0;
        bus.sel_error = 0; bus.n_row = 0; bus.win = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fire_pulse", bus.fire_pulse, 0);
        chk("rst_load_en", bus.load_en, 0);
        chk("rst_move_count", bus.move_count, 0);
        chk("rst_game_won", bus.game_won, 0);
        reset_n = 1'b1;
        // plain clear
        ng_pulse(16, 1'b0);
        wait_idle();
        chk("clear_loads_left", lq.size(), 0);
        chk("clear_move_count", bus.move_count, 0);
        // directed row strike, then a fire edge during settle must be dropped
        do_fire(4'b0100, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fire_one_cycle", bus.fire_pulse, 0);
        bus.sel_code = 4'b0001; bus.n_row = 1'b0; bus.fire_req = 1'b1;
        @(negedge clk);
        chk("drop_in_settle", bus.fire_pulse, 0);
        bus.fire_req = 1'b0;
        wait_idle();
        chk("move_count_t3", bus.move_count, mc);
        do_fire(4'b0110, 1'b0, 1'b0, 1'b1);
        do_fire(4'b0010, 1'b1, 1'b1, 1'b1);
        do_fire(4'b0000, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("invalid_no_count", bus.move_count, mc);
        // random play, then saturate the move counter
        for (int i = 0; i < 30; i++) begin
            sel = ($urandom_range(0, 9) < 7) ? 4'b0001 << $urandom_range(0, 3) : 4'($urandom_range(0, 15));
            do_fire(sel, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
            chk("rand_move_count", bus.move_count, mc);
        end
        while (mc < 255) begin
            do_fire(4'b0001 << $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
        end
        chk("move_count_255", bus.move_count, 255);
        // winning strike at max count; fires then ignored until a scrambled new game
        bus.win = 1'b1;
        do_fire(4'b1000, 1'b0, 1'b1, 1'b1);
        wait_idle();
        chk("saturate_255", bus.move_count, 255);
        chk("won_flag", bus.game_won, 1);
        do_fire(4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("won_frozen_count", bus.move_count, 255);
        chk("won_still", bus.game_won, 1);
        ng_pulse(16, 1'b1);
        chk("won_cleared", bus.game_won, 0);
        wait_idle();
        bus.win = 1'b0;
        chk("scramble_strikes_left", sq.size(), 0);
        chk("scramble_move_count", bus.move_count, 0);
        chk("scramble_busy", bus.busy, 0);
        // new game aborting a clear in progress
        ng_pulse(4, 1'b0);
        repeat (2) @(negedge clk);
        ng_pulse(16, 1'b0);
        wait_idle();
        chk("abort_loads_left", lq.size(), 0);
        // reset during S_FIRE
        do_fire(4'b0010, 1'b0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_fire_pulse", bus.fire_pulse, 0);
        chk("t1_row_en", bus.row_en, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_move_count", bus.move_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mlfsr = 16'hACE1;
        repeat (2) @(negedge clk);
        chk("t1_idle_busy", bus.busy, 1);
        chk("t1_idle_won", bus.game_won, 0);
        ng_pulse(16, 1'b1);
        wait_idle();
        chk("final_strikes_left", sq.size(), 0);
        chk("final_loads_left", lq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
